id_ex_debug_reader: RTL

- Debug-side reader for the ID/EX pipeline latch.
- On a start request it snapshots all latched ID/EX fields in one cycle.
- It then streams them as a fixed 15-byte frame over a valid/ready byte interface toward the debug UART transmitter.
- It lets the debug host inspect the EX-stage inputs after each i_step without disturbing the pipeline.

---
 rtl/id_ex_debug_reader_if.sv | 12 +
 rtl/id_ex_debug_reader.sv | 119 +++++++++++
 2 files changed

// File: rtl/id_ex_debug_reader_if.sv
// Byte-wide valid/ready stream from the ID/EX debug reader toward the debug UART transmitter.
// The master drives valid and data. The slave returns ready.
interface id_ex_debug_reader_if #(
    parameter int NB_BYTE = 8
) ();
    logic               o_tx_valid;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               i_tx_ready;

    modport master (output o_tx_valid, output o_tx_data, input i_tx_ready);
    modport slave  (input o_tx_valid, input o_tx_data, output i_tx_ready);
endinterface

// File: rtl/id_ex_debug_reader.sv
// Snapshots the ID/EX latch on i_start and streams it as a fixed 3+3*NB/8 byte frame.
// Multi-byte fields are sent MSB first.
module id_ex_debug_reader #(
    parameter int NB        = 32,
    parameter int NB_OPCODE = 6,
    parameter int NB_FCODE  = 6,
    parameter int NB_BYTE   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_FCODE-1:0]  i_instruction_funct_code,
    input  logic [NB_OPCODE-1:0] i_instruction_op_code,
    input  logic                 i_alu_src,
    input  logic [NB-1:0]        i_data_a,
    input  logic [NB-1:0]        i_data_b,
    input  logic [NB-1:0]        i_extension_result,
    id_ex_debug_reader_if.master tx,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int NB_WORD   = NB / 8;
    localparam int NUM_BYTES = 3 + 3 * NB_WORD;
    localparam int NB_IDX    = $clog2(NUM_BYTES);
    localparam int LAST      = NUM_BYTES - 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [NB_IDX-1:0]    r_idx, w_idx_nxt;
    logic                 w_capture;

    logic [NB_FCODE-1:0]  r_funct;
    logic [NB_OPCODE-1:0] r_opcode;
    logic                 r_alu_src;
    logic [NB-1:0]        r_data_a, r_data_b, r_ext;

    // Padded to a power of two so any index value selects a defined byte.
    logic [2**NB_IDX-1:0][NB_BYTE-1:0] w_frame;

    always_comb begin
        w_frame    = '0;
        w_frame[0] = NB_BYTE'(r_funct);
        w_frame[1] = NB_BYTE'(r_opcode);
        w_frame[2] = NB_BYTE'(r_alu_src);
        for (int i = 0; i < NB_WORD; i++) begin
            w_frame[3 + i]             = NB_BYTE'(r_data_a[NB-1-8*i -: 8]);
            w_frame[3 + NB_WORD + i]   = NB_BYTE'(r_data_b[NB-1-8*i -: 8]);
            w_frame[3 + 2*NB_WORD + i] = NB_BYTE'(r_ext[NB-1-8*i -: 8]);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_funct   <= '0;
            r_opcode  <= '0;
            r_alu_src <= 1'b0;
            r_data_a  <= '0;
            r_data_b  <= '0;
            r_ext     <= '0;
        end else if (w_capture) begin
            r_funct   <= i_instruction_funct_code;
            r_opcode  <= i_instruction_op_code;
            r_alu_src <= i_alu_src;
            r_data_a  <= i_data_a;
            r_data_b  <= i_data_b;
            r_ext     <= i_extension_result;
        end
    end

    // Outputs decode straight from state so an async reset silences the bus at once.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_capture     = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        tx.o_tx_valid = 1'b0;
        tx.o_tx_data  = '0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                o_busy        = 1'b1;
                tx.o_tx_valid = 1'b1;
                tx.o_tx_data  = w_frame[r_idx];
                if (tx.i_tx_ready) begin
                    if (r_idx == NB_IDX'(LAST)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule
